rsa_job_scheduler: RTL and testbench
====================================

// Module: rsa_job_scheduler
// PURPOSE
//  Sequences a batch of RSA jobs across KERNEL_NUM kernels. Fetches fixed-size job descriptors
//  from memory starting at a base address and dispatches each to a free kernel, round-robin.
//  Tracks completion and raises done when every job has finished. Sits between the global
//  control registers (start/base/count) and the kernel array.
// PARAMETERS
//  KERNEL_NUM  8    number of kernels (2..16)
//  DESC_W      128  descriptor width in bits
//  JOB_STRIDE  128  byte distance between consecutive descriptors
// PORTS
//  clk             in   1           clock
//  rst_n           in   1           asynchronous reset, active-low
//  start           in   1           1-cycle pulse; launches a batch
//  abort           in   1           1-cycle pulse; cancels the batch
//  base_addr       in   64          address of descriptor 0
//  job_count       in   32          number of jobs in the batch
//  fetch_valid     out  1           descriptor fetch request
//  fetch_ready     in   1           fetch request accepted
//  fetch_addr      out  64          descriptor address
//  desc_valid      in   1           descriptor data valid
//  desc_ready      out  1           scheduler accepts descriptor
//  desc_data       in   DESC_W      descriptor payload
//  kernel_start    out  KERNEL_NUM  one-hot, 1-cycle dispatch pulse
//  kernel_desc     out  DESC_W      descriptor for the started kernel; held until next dispatch
//  kernel_done     in   KERNEL_NUM  per-kernel done level; rising edge = job finished
//  busy            out  1           batch in progress (state != IDLE/DONE)
//  done            out  1           batch complete; held until next start
//  dispatched_cnt  out  32          jobs dispatched in the current batch
//  completed_cnt   out  32          jobs completed in the current batch
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE, rr_ptr=0, kbusy=0, done_prev=all ones.
//  FSM states:
//   IDLE/DONE: start latches base_addr and job_count, clears both counters, clears done,
//     and sets idx=0. Next state is FETCH, or DONE if job_count==0 (done=1 on the next cycle).
//   FETCH: fetch_valid=1, fetch_addr=base+idx*JOB_STRIDE (mod 2^64). Stable until fetch_ready.
//     The handshake moves to WAIT_DESC. fetch_valid rises 1 cycle after start.
//   WAIT_DESC: desc_ready=1. On the desc_valid handshake, capture desc_data and go to DISPATCH.
//   DISPATCH: sel = first k with kbusy[k]==0, scanning rr_ptr, rr_ptr+1, ... mod KERNEL_NUM.
//     If none is free, wait. Otherwise: kernel_start[sel]=1 for 1 cycle, kernel_desc=captured
//     descriptor, kbusy[sel]=1, rr_ptr=sel+1 (wraps), dispatched_cnt++, idx++.
//     Go to DRAIN if dispatched_cnt+1==job_count, else FETCH.
//   DRAIN: wait until kbusy==0, then go to DONE with done=1.
//  Only one fetch is outstanding at a time. No new fetch issues until the prior job is dispatched.
//  Completion detection:
//   - done_prev is registered from kernel_done.
//   - edge[k] = kernel_done[k] & ~done_prev[k].
//   - An edge with kbusy[k]=1 clears kbusy[k] and increments completed_cnt.
//   - An edge on an idle kernel is ignored.
//   - Multiple edges in one cycle add popcount(edge & kbusy).
//   - An edge on kernel a and a dispatch to kernel b in the same cycle both take effect.
//     Kernel a is not eligible as sel in that cycle; it is eligible the next cycle.
//  start while busy=1 is ignored.
//  abort in any state: go to IDLE next cycle; kbusy=0; fetch_valid/desc_ready drop; done stays 0.
//    Counters hold their values for readback. abort has priority over start in the same cycle.
//  Counters are 32-bit and wrap. job_count is a 32-bit unsigned value.
// TESTING
//  1. job_count=3, base=0x1000, all kernels idle -> fetch_addr 0x1000/0x1080/0x1100.
//     kernel_start 0x01, 0x02, 0x04. done after 3 kernel_done edges. completed_cnt=3.
//  2. job_count=0 + start -> no fetch_valid, done=1 two cycles after start.
//  3. KERNEL_NUM=8, job_count=10, kernels never complete -> 8 dispatches then stall in DISPATCH.
//     Raise kernel_done[3] -> 9th job starts on kernel 3.
//  4. fetch_ready and desc_valid held low for 20 cycles -> fetch_addr stable, no kernel_start.
//     Release -> dispatch proceeds.
//  5. Same-cycle kernel_done edges on kernels 0 and 5 -> completed_cnt +2. Spurious edge on
//     idle kernel 6 -> no change.
//  6. abort mid-batch with 4 kernels busy -> IDLE, busy=0, done=0. New start runs a clean batch
//     from rr_ptr unchanged.

Source files
------------

// File: rtl/rsa_job_scheduler.sv
// rsa_job_scheduler: walks a batch of fixed-size RSA job descriptors in memory,
// hands each one to the next free kernel in round-robin order, and counts
// completions until the whole batch has drained.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no batch since reset/abort; waits for start
// FETCH     | requesting descriptor idx at base + idx*JOB_STRIDE
// WAIT_DESC | fetch accepted; waiting for descriptor data
// DISPATCH  | holding a descriptor; waiting for a free kernel
// DRAIN     | every job dispatched; waiting for all kernels to finish
// DONE      | batch complete; done is held until the next start
module rsa_job_scheduler #(
    parameter int KERNEL_NUM = 8,
    parameter int DESC_W     = 128,
    parameter int JOB_STRIDE = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [63:0]           base_addr,
    input  logic [31:0]           job_count,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [63:0]           fetch_addr,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [DESC_W-1:0]     desc_data,
    output logic [KERNEL_NUM-1:0] kernel_start,
    output logic [DESC_W-1:0]     kernel_desc,
    input  logic [KERNEL_NUM-1:0] kernel_done,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           dispatched_cnt,
    output logic [31:0]           completed_cnt
);

    localparam int PTR_W = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_DESC = 3'd2;
    localparam logic [2:0] S_DISPATCH  = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]            state;
    logic [63:0]           base_q;
    logic [31:0]           count_q;
    logic [31:0]           idx_q;
    logic [DESC_W-1:0]     desc_q;
    logic [PTR_W-1:0]      rr_ptr;
    logic [KERNEL_NUM-1:0] kbusy;
    logic [KERNEL_NUM-1:0] done_prev;
    logic [KERNEL_NUM-1:0] done_edge;
    logic [KERNEL_NUM-1:0] cpl_mask;
    logic [KERNEL_NUM-1:0] sel_onehot;
    logic [PTR_W-1:0]      sel;
    logic [PTR_W-1:0]      scan_k;
    logic                  sel_found;
    logic [31:0]           cpl_inc;
    logic                  do_dispatch;
    logic                  idle_like;

    // Only rising edges of the done level count, and only on kernels we own.
    assign done_edge = kernel_done & ~done_prev;
    assign cpl_mask  = done_edge & kbusy;

    assign idle_like   = (state == S_IDLE) || (state == S_DONE);
    assign busy        = !idle_like;
    assign fetch_valid = (state == S_FETCH);
    assign desc_ready  = (state == S_WAIT_DESC);
    assign fetch_addr  = base_q + (64'(idx_q) * 64'(JOB_STRIDE));

    // Scan from rr_ptr for the first kernel not currently busy. Uses the
    // registered kbusy, so a kernel finishing this cycle is only eligible next cycle.
    always_comb begin
        sel        = '0;
        scan_k     = '0;
        sel_found  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            scan_k = PTR_W'((int'(rr_ptr) + i) % KERNEL_NUM);
            if (!sel_found && !kbusy[scan_k]) begin
                sel_found          = 1'b1;
                sel                = scan_k;
                sel_onehot[scan_k] = 1'b1;
            end
        end
    end

    // Number of owned kernels that finished this cycle.
    always_comb begin
        cpl_inc = '0;
        for (int i = 0; i < KERNEL_NUM; i++) begin
            cpl_inc = cpl_inc + 32'(cpl_mask[i]);
        end
    end

    assign do_dispatch = (state == S_DISPATCH) && sel_found && !abort;

    // Batch sequencing FSM; abort overrides everything, including start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            desc_q  <= '0;
            done    <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= job_count;
                        idx_q   <= '0;
                        done    <= 1'b0;
                        state   <= (job_count == 32'd0) ? S_DONE : S_FETCH;
                    end else if (state == S_DONE) begin
                        done <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_ready) state <= S_WAIT_DESC;
                end
                S_WAIT_DESC: begin
                    if (desc_valid) begin
                        desc_q <= desc_data;
                        state  <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (sel_found) begin
                        idx_q <= idx_q + 32'd1;
                        state <= (dispatched_cnt + 32'd1 == count_q) ? S_DRAIN : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (kbusy == '0) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Batch counters: cleared by an accepted start, frozen by abort for readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatched_cnt <= '0;
            completed_cnt  <= '0;
        end else if (abort) begin
            dispatched_cnt <= dispatched_cnt;
            completed_cnt  <= completed_cnt;
        end else if (start && idle_like) begin
            dispatched_cnt <= '0;
            completed_cnt  <= '0;
        end else begin
            if (do_dispatch) dispatched_cnt <= dispatched_cnt + 32'd1;
            completed_cnt <= completed_cnt + cpl_inc;
        end
    end

    // Kernel ownership, round-robin pointer and the dispatch pulse/descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbusy        <= '0;
            rr_ptr       <= '0;
            kernel_start <= '0;
            kernel_desc  <= '0;
            done_prev    <= '1;
        end else begin
            done_prev    <= kernel_done;
            kernel_start <= do_dispatch ? sel_onehot : '0;
            if (do_dispatch) begin
                kernel_desc <= desc_q;
                if (int'(sel) == KERNEL_NUM - 1) rr_ptr <= '0;
                else                             rr_ptr <= sel + 1'b1;
            end
            if (abort) kbusy <= '0;
            else       kbusy <= (kbusy & ~cpl_mask) | (do_dispatch ? sel_onehot : '0);
        end
    end

endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench for rsa_job_scheduler; the bench plays memory and the kernels.
module tb_rsa_job_scheduler;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [63:0]   base_addr;
    logic [31:0]   job_count;
    logic          fetch_valid, fetch_ready;
    logic [63:0]   fetch_addr;
    logic          desc_valid, desc_ready;
    logic [127:0]  desc_data;
    logic [7:0]    kernel_start;
    logic [127:0]  kernel_desc;
    logic [7:0]    kernel_done;
    logic          busy, done;
    logic [31:0]   dispatched_cnt, completed_cnt;

    int n_chk = 0;
    int n_bad = 0;

    rsa_job_scheduler #(.KERNEL_NUM(8), .DESC_W(128), .JOB_STRIDE(128)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .job_count(job_count),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
        .kernel_start(kernel_start), .kernel_desc(kernel_desc), .kernel_done(kernel_done),
        .busy(busy), .done(done),
        .dispatched_cnt(dispatched_cnt), .completed_cnt(completed_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] mkdesc(input logic [63:0] a);
        return {a ^ 64'hC0DE_0000_5A5A_0000, a};
    endfunction

    task automatic pulse_start(input logic [63:0] b, input logic [31:0] n);
        base_addr = b;
        job_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fetch(input string tag);
        int t = 0;
        while (!fetch_valid && t < 40) begin tick(); t++; end
        check_val({tag, "_fv"}, fetch_valid, 1'b1);
    endtask

    task automatic fetch_and_desc(input string tag, input logic [63:0] addr);
        wait_fetch(tag);
        check_val({tag, "_addr"}, fetch_addr, addr);
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        desc_valid = 1'b1;
        desc_data = mkdesc(addr);
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_kstart(input string tag, input logic [7:0] exp_ks, input logic [63:0] addr);
        int t = 0;
        while (kernel_start == 8'h0 && t < 40) begin tick(); t++; end
        check_val({tag, "_ks"}, kernel_start, exp_ks);
        check_val({tag, "_kd"}, kernel_desc, mkdesc(addr));
    endtask

    task automatic serve_job(input string tag, input logic [63:0] addr, input logic [7:0] exp_ks);
        fetch_and_desc(tag, addr);
        wait_kstart(tag, exp_ks, addr);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 20) begin tick(); t++; end
        check_val({tag, "_done"}, done, 1'b1);
        check_val({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; job_count = '0;
        fetch_ready = 1'b0; desc_valid = 1'b0; desc_data = '0; kernel_done = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_fv", fetch_valid, 1'b0);
        check_val("rst_ks", kernel_start, 8'h0);
        check_val("rst_disp", dispatched_cnt, 32'd0);

        // 1: three jobs, kernels 0..2, three completions
        pulse_start(64'h1000, 32'd3);
        check_val("t1_fv_rise", fetch_valid, 1'b1);
        check_val("t1_busy", busy, 1'b1);
        serve_job("t1_j0", 64'h1000, 8'h01);
        serve_job("t1_j1", 64'h1080, 8'h02);
        serve_job("t1_j2", 64'h1100, 8'h04);
        check_val("t1_disp", dispatched_cnt, 32'd3);
        check_val("t1_notdone", done, 1'b0);
        kernel_done = 8'h01; tick();
        kernel_done = 8'h03; tick();
        kernel_done = 8'h07; tick();
        wait_done("t1");
        check_val("t1_cpl", completed_cnt, 32'd3);
        kernel_done = 8'h00; tick();

        // 2: empty batch
        pulse_start(64'h9000, 32'd0);
        check_val("t2_fv", fetch_valid, 1'b0);
        check_val("t2_done_lo", done, 1'b0);
        tick();
        check_val("t2_done_hi", done, 1'b1);
        check_val("t2_fv2", fetch_valid, 1'b0);

        // 4: handshake stalls (rr_ptr is 3 here)
        pulse_start(64'h2000, 32'd2);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fetch_valid !== 1'b1 || fetch_addr !== 64'h2000 || kernel_start !== 8'h0) bad = 1'b1;
        end
        check_val("t4_fetch_hold", bad, 1'b0);
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (desc_ready !== 1'b1 || kernel_start !== 8'h0) bad = 1'b1;
        end
        check_val("t4_desc_hold", bad, 1'b0);
        desc_valid = 1'b1; desc_data = mkdesc(64'h2000); tick(); desc_valid = 1'b0;
        wait_kstart("t4_j0", 8'h08, 64'h2000);
        serve_job("t4_j1", 64'h2080, 8'h10);
        kernel_done = 8'h18; tick();
        check_val("t4_cpl2", completed_cnt, 32'd2);
        wait_done("t4");
        kernel_done = 8'h00; tick();

        // 5: simultaneous and spurious completions (rr_ptr is 5)
        pulse_start(64'h3000, 32'd4);
        serve_job("t5_j0", 64'h3000, 8'h20);
        serve_job("t5_j1", 64'h3080, 8'h40);
        serve_job("t5_j2", 64'h3100, 8'h80);
        serve_job("t5_j3", 64'h3180, 8'h01);
        kernel_done = 8'h21; tick();
        check_val("t5_pair", completed_cnt, 32'd2);
        kernel_done = 8'h61; tick();
        check_val("t5_k6", completed_cnt, 32'd3);
        kernel_done = 8'h21; tick();
        kernel_done = 8'h61; tick();
        check_val("t5_spur", completed_cnt, 32'd3);
        check_val("t5_busy", busy, 1'b1);
        kernel_done = 8'hE1; tick();
        wait_done("t5");
        check_val("t5_cpl", completed_cnt, 32'd4);
        kernel_done = 8'h00; tick();

        // 3: ten jobs, kernels never finish (rr_ptr is 1)
        pulse_start(64'h10000, 32'd10);
        for (int i = 0; i < 8; i++) begin
            serve_job("t3_j", 64'h10000 + 64'(i) * 64'h80, 8'(1 << ((i + 1) % 8)));
        end
        fetch_and_desc("t3_j8", 64'h10400);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (kernel_start !== 8'h0) bad = 1'b1;
        end
        check_val("t3_stall", bad, 1'b0);
        check_val("t3_disp8", dispatched_cnt, 32'd8);
        kernel_done = 8'h08; tick();
        wait_kstart("t3_j8", 8'h08, 64'h10400);
        check_val("t3_disp9", dispatched_cnt, 32'd9);
        abort = 1'b1; tick(); abort = 1'b0;
        check_val("t3_abort_busy", busy, 1'b0);
        kernel_done = 8'h00; tick();

        // 6: abort with four kernels busy (rr_ptr is 4), then a clean batch
        pulse_start(64'h4000, 32'd6);
        serve_job("t6_j0", 64'h4000, 8'h10);
        serve_job("t6_j1", 64'h4080, 8'h20);
        serve_job("t6_j2", 64'h4100, 8'h40);
        serve_job("t6_j3", 64'h4180, 8'h80);
        abort = 1'b1; tick(); abort = 1'b0;
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_done", done, 1'b0);
        check_val("t6_fv", fetch_valid, 1'b0);
        check_val("t6_disp_hold", dispatched_cnt, 32'd4);
        tick();
        check_val("t6_fv_later", fetch_valid, 1'b0);
        base_addr = 64'h7000; job_count = 32'd1;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check_val("t6_abort_prio", busy, 1'b0);
        pulse_start(64'h5000, 32'd1);
        check_val("t6_clr", dispatched_cnt, 32'd0);
        serve_job("t6_new", 64'h5000, 8'h01);
        kernel_done = 8'h01; tick();
        wait_done("t6");
        check_val("t6_cpl", completed_cnt, 32'd1);
        check_val("t6_disp", dispatched_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
